// File: rtl/distance_meas.sv
// Ultrasonic ranging front end: periodic trigger, echo-width timing in us,
// scaling to mm with saturation, sequential binary-to-BCD, one-cycle result strobe.
module distance_meas #(
    parameter int CLK_FREQ_MHZ    = 50,
    parameter int TRIG_US         = 10,
    parameter int PERIOD_MS       = 60,
    parameter int ECHO_TIMEOUT_US = 38000,
    parameter int MAX_MM          = 4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        echo,
    output logic        trig,
    output logic [23:0] distance_data,
    output logic        data_vld,
    output logic        out_range
);

    localparam int PERIOD_CLKS = PERIOD_MS * 1000 * CLK_FREQ_MHZ;
    localparam int PER_W       = $clog2(PERIOD_CLKS);
    localparam int PS_W        = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int TRIG_CLKS   = TRIG_US * CLK_FREQ_MHZ;
    localparam logic [13:0] MM_SCALE = 14'd11300;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, CONV, BCD, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         echo_sync_reg;
    logic [PS_W-1:0]    ps_reg, ps_next;
    logic [PER_W-1:0]   per_reg, per_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic               tmo_reg, tmo_next;
    logic               ovf_reg, ovf_next;
    logic [12:0]        bin_reg, bin_next;
    logic [15:0]        bcd_reg, bcd_next;
    logic [3:0]         step_reg, step_next;
    logic               ps_clr, load_out;
    logic               echo_rise, echo_fall, us_tick, per_wrap;
    logic [29:0]        product;
    logic [13:0]        mm_raw;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_shift;

    assign echo_rise = echo_sync_reg[1] & ~echo_sync_reg[2];
    assign echo_fall = ~echo_sync_reg[1] & echo_sync_reg[2];
    assign us_tick   = (ps_reg == PS_W'(CLK_FREQ_MHZ - 1));
    assign per_wrap  = (per_reg == PER_W'(PERIOD_CLKS - 1));
    assign ps_next   = (ps_clr || us_tick) ? '0 : ps_reg + PS_W'(1);
    // Period is counted in clk so trigger spacing stays exact when the us prescaler is re-phased.
    assign per_next  = per_wrap ? '0 : per_reg + PER_W'(1);

    assign product = 30'(cnt_reg) * 30'(MM_SCALE);
    assign mm_raw  = product[29:16];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate
    assign bcd_shift = {bcd_adj[14:0], bin_reg[12]};

    assign trig = (state_reg == TRIG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            echo_sync_reg <= '0;
            ps_reg        <= '0;
            per_reg       <= '0;
            cnt_reg       <= '0;
            tmo_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            step_reg      <= '0;
            distance_data <= '0;
            out_range     <= 1'b0;
            data_vld      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            echo_sync_reg <= {echo_sync_reg[1:0], echo};
            ps_reg        <= ps_next;
            per_reg       <= per_next;
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            ovf_reg       <= ovf_next;
            bin_reg       <= bin_next;
            bcd_reg       <= bcd_next;
            step_reg      <= step_next;
            data_vld      <= load_out;
            if (load_out) begin
                distance_data <= {8'h00, bcd_shift};
                out_range     <= ovf_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        ovf_next   = ovf_reg;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        step_next  = step_reg;
        ps_clr     = 1'b0;
        load_out   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (per_wrap) begin
                    state_next = TRIG;
                    cnt_next   = '0;
                    tmo_next   = 1'b0;
                    ps_clr     = 1'b1;
                end
            end
            // cnt_reg is shared: clk count in TRIG, us count in WAIT_ECHO and MEASURE.
            TRIG: begin
                if (cnt_reg == 16'(TRIG_CLKS - 1)) begin
                    state_next = WAIT_ECHO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
                end else if (us_tick) begin
                    if (cnt_reg == 16'(ECHO_TIMEOUT_US - 1)) begin
                        state_next = CONV;
                        tmo_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            MEASURE: begin
                if (us_tick && cnt_reg == 16'(ECHO_TIMEOUT_US - 1)) begin
                    state_next = CONV;
                    tmo_next   = 1'b1;
                    cnt_next   = cnt_reg + 16'd1;
                end else if (echo_fall) begin
                    // A tick landing on the fall cycle completes the last whole us.
                    state_next = CONV;
                    cnt_next   = cnt_reg + {15'd0, us_tick};
                end else if (us_tick) begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            CONV: begin
                state_next = BCD;
                bcd_next   = '0;
                step_next  = '0;
                if (tmo_reg || mm_raw > 14'(MAX_MM)) begin
                    bin_next = 13'(MAX_MM);
                    ovf_next = 1'b1;
                end else begin
                    bin_next = mm_raw[12:0];
                    ovf_next = 1'b0;
                end
            end
            BCD: begin
                bcd_next  = bcd_shift;
                bin_next  = {bin_reg[11:0], 1'b0};
                step_next = step_reg + 4'd1;
                if (step_reg == 4'd12) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule
